// File: rtl/stack_ptr_unit.sv
// Stack-pointer unit: SP register with push/pop/load, bounds checks, sticky faults and a RUN/FAULT FSM.
// Optional low-water-mark tracking is enabled by defining STACK_WATERMARK_EN.
module stack_ptr_unit #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] LIMIT     = WIDTH'(16'hFF00),
    parameter logic [WIDTH-1:0] STEP      = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
`ifdef STACK_WATERMARK_EN
    input  logic             wm_clr,
    output logic [WIDTH-1:0] watermark,
`endif
    input  logic             push,
    input  logic             pop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_fault,
    output logic [WIDTH-1:0] sp,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow,
    output logic             load_err,
    output logic             fault
);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sp_next;
    logic             overflow_next;
    logic             underflow_next;
    logic             load_err_next;
    logic [WIDTH-1:0] room_below;
    logic [WIDTH-1:0] room_above;
    logic             load_ok;

    // Bounds are checked on differences so sp can never wrap past either end.
    assign room_below = sp - LIMIT;
    assign room_above = RESET_VAL - sp;
    assign load_ok    = (load_val - LIMIT) <= (RESET_VAL - LIMIT);

    assign empty = (sp == RESET_VAL);
    assign full  = (room_below < STEP);
    assign fault = (state == FAULT);

    always_comb begin
        sp_next        = sp;
        overflow_next  = overflow;
        underflow_next = underflow;
        load_err_next  = load_err;
        state_next     = state;

        if (clr_fault) begin
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
            load_err_next  = 1'b0;
            state_next     = RUN;
        end else if (load) begin
            if (load_ok) begin
                sp_next = load_val;
            end else begin
                load_err_next = 1'b1;
                state_next    = FAULT;
            end
        end else if (state == RUN && push && !pop) begin
            if (full) begin
                overflow_next = 1'b1;
                state_next    = FAULT;
            end else begin
                sp_next = sp - STEP;
            end
        end else if (state == RUN && pop && !push) begin
            if (room_above < STEP) begin
                underflow_next = 1'b1;
                state_next     = FAULT;
            end else begin
                sp_next = sp + STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp        <= RESET_VAL;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            load_err  <= 1'b0;
            state     <= RUN;
        end else begin
            sp        <= sp_next;
            overflow  <= overflow_next;
            underflow <= underflow_next;
            load_err  <= load_err_next;
            state     <= state_next;
        end
    end

`ifdef STACK_WATERMARK_EN
    // Tracks the registered sp, so the mark trails sp by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            watermark <= RESET_VAL;
        end else if (wm_clr) begin
            watermark <= sp;
        end else if (sp < watermark) begin
            watermark <= sp;
        end
    end
`endif

endmodule

// File: tb/tb_stack_ptr_unit.sv
// Bench for stack_ptr_unit: two instances (STEP=1/LIMIT=0xFFFC and STEP=2/LIMIT=0xFFF8) share one
// stimulus stream; directed steps plus random traffic are checked against a behavioural model.
module tb_stack_ptr_unit;

    localparam int RV = 16'hFFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        push;
    logic        pop;
    logic        load;
    logic [15:0] load_val;
    logic        clr_fault;
`ifdef STACK_WATERMARK_EN
    logic        wm_clr;
    logic [15:0] wm_o [2];
    int          m_wm [2];
`endif

    logic [15:0] sp_o [2];
    logic        empty_o [2];
    logic        full_o [2];
    logic        ov_o [2];
    logic        un_o [2];
    logic        le_o [2];
    logic        flt_o [2];

    int checks = 0;
    int errors = 0;

    // Reference model state per instance
    int lim [2] = '{16'hFFFC, 16'hFFF8};
    int stp [2] = '{1, 2};
    int m_sp [2];
    bit m_ov [2];
    bit m_un [2];
    bit m_le [2];
    bit m_flt [2];

    always #5 clk = ~clk;

    stack_ptr_unit #(.WIDTH(16), .RESET_VAL(16'hFFFF), .LIMIT(16'hFFFC), .STEP(16'd1)) u_a (
        .clk(clk), .reset(reset),
`ifdef STACK_WATERMARK_EN
        .wm_clr(wm_clr), .watermark(wm_o[0]),
`endif
        .push(push), .pop(pop), .load(load), .load_val(load_val), .clr_fault(clr_fault),
        .sp(sp_o[0]), .empty(empty_o[0]), .full(full_o[0]), .overflow(ov_o[0]),
        .underflow(un_o[0]), .load_err(le_o[0]), .fault(flt_o[0])
    );

    stack_ptr_unit #(.WIDTH(16), .RESET_VAL(16'hFFFF), .LIMIT(16'hFFF8), .STEP(16'd2)) u_b (
        .clk(clk), .reset(reset),
`ifdef STACK_WATERMARK_EN
        .wm_clr(wm_clr), .watermark(wm_o[1]),
`endif
        .push(push), .pop(pop), .load(load), .load_val(load_val), .clr_fault(clr_fault),
        .sp(sp_o[1]), .empty(empty_o[1]), .full(full_o[1]), .overflow(ov_o[1]),
        .underflow(un_o[1]), .load_err(le_o[1]), .fault(flt_o[1])
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural rules: stack depth is counted in words between the top and the limit.
    task automatic model_step(input int i, input bit rs, input bit cf, input bit ld, input int lv,
                              input bit pu, input bit po, input bit wc);
        int old_sp;
        old_sp = m_sp[i];
`ifdef STACK_WATERMARK_EN
        if (rs)                   m_wm[i] = RV;
        else if (wc)              m_wm[i] = old_sp;
        else if (old_sp < m_wm[i]) m_wm[i] = old_sp;
`endif
        if (rs) begin
            m_sp[i] = RV; m_ov[i] = 0; m_un[i] = 0; m_le[i] = 0; m_flt[i] = 0;
        end else if (cf) begin
            m_ov[i] = 0; m_un[i] = 0; m_le[i] = 0; m_flt[i] = 0;
        end else if (ld) begin
            if (lv >= lim[i] && lv <= RV) m_sp[i] = lv;
            else begin m_le[i] = 1; m_flt[i] = 1; end
        end else if (!m_flt[i] && pu && !po) begin
            if (old_sp - stp[i] >= lim[i]) m_sp[i] = old_sp - stp[i];
            else begin m_ov[i] = 1; m_flt[i] = 1; end
        end else if (!m_flt[i] && po && !pu) begin
            if (old_sp + stp[i] <= RV) m_sp[i] = old_sp + stp[i];
            else begin m_un[i] = 1; m_flt[i] = 1; end
        end
    endtask

    task automatic compare_model(input int i);
        string p;
        p = (i == 0) ? "a" : "b";
        check({p, ".sp"},        sp_o[i],           16'(m_sp[i]));
        check({p, ".empty"},     16'(empty_o[i]),   16'(m_sp[i] == RV));
        check({p, ".full"},      16'(full_o[i]),    16'((m_sp[i] - lim[i]) < stp[i]));
        check({p, ".overflow"},  16'(ov_o[i]),      16'(m_ov[i]));
        check({p, ".underflow"}, 16'(un_o[i]),      16'(m_un[i]));
        check({p, ".load_err"},  16'(le_o[i]),      16'(m_le[i]));
        check({p, ".fault"},     16'(flt_o[i]),     16'(m_flt[i]));
`ifdef STACK_WATERMARK_EN
        check({p, ".watermark"}, wm_o[i],           16'(m_wm[i]));
`endif
    endtask

    task automatic cycle(input bit rs, input bit cf, input bit ld, input logic [15:0] lv,
                         input bit pu, input bit po, input bit wc);
        reset = rs; clr_fault = cf; load = ld; load_val = lv; push = pu; pop = po;
`ifdef STACK_WATERMARK_EN
        wm_clr = wc;
`endif
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i, rs, cf, ld, int'(lv), pu, po, wc);
        #1;
        for (int i = 0; i < 2; i++) compare_model(i);
    endtask

    //             rs cf ld lv         pu po wc
    initial begin
        for (int i = 0; i < 2; i++) begin
            m_sp[i] = RV; m_ov[i] = 0; m_un[i] = 0; m_le[i] = 0; m_flt[i] = 0;
`ifdef STACK_WATERMARK_EN
            m_wm[i] = RV;
`endif
        end
        #1;
        cycle(1, 0, 0, 16'h0, 0, 0, 0);
        check("rst.sp", sp_o[0], 16'hFFFF);
        check("rst.empty", 16'(empty_o[0]), 16'd1);
        check("rst.full", 16'(full_o[0]), 16'd0);
        check("rst.fault", 16'(flt_o[0]), 16'd0);

        repeat (3) cycle(0, 0, 0, 16'h0, 1, 0, 0);
        check("push3.sp", sp_o[0], 16'hFFFC);
        check("push3.full", 16'(full_o[0]), 16'd1);
        check("push3.empty", 16'(empty_o[0]), 16'd0);
        check("push3.b.sp", sp_o[1], 16'hFFF9);

        cycle(0, 0, 0, 16'h0, 1, 0, 0);
        check("ovf.sp", sp_o[0], 16'hFFFC);
        check("ovf.flag", 16'(ov_o[0]), 16'd1);
        check("ovf.fault", 16'(flt_o[0]), 16'd1);
        check("ovf.b.flag", 16'(ov_o[1]), 16'd1);
`ifdef STACK_WATERMARK_EN
        check("wm.b.low", wm_o[1], 16'hFFF9);
`endif
        cycle(0, 0, 0, 16'h0, 0, 1, 0);
        check("fault_pop.sp", sp_o[0], 16'hFFFC);
        cycle(0, 1, 0, 16'h0, 0, 0, 0);
        check("clr.ovf", 16'(ov_o[0]), 16'd0);
        check("clr.fault", 16'(flt_o[0]), 16'd0);
        cycle(0, 0, 0, 16'h0, 0, 1, 0);
        check("pop.sp", sp_o[0], 16'hFFFD);
        cycle(0, 0, 0, 16'h0, 0, 1, 0);
        check("pop2.b.sp", sp_o[1], 16'hFFFD);
        cycle(0, 0, 0, 16'h0, 0, 0, 1);
`ifdef STACK_WATERMARK_EN
        check("wm_clr.b", wm_o[1], 16'hFFFD);
`endif

        cycle(1, 0, 0, 16'h0, 0, 0, 0);
        cycle(0, 0, 0, 16'h0, 0, 1, 0);
        check("unf.flag", 16'(un_o[0]), 16'd1);
        check("unf.fault", 16'(flt_o[0]), 16'd1);
        check("unf.sp", sp_o[0], 16'hFFFF);

        cycle(1, 0, 0, 16'h0, 0, 0, 0);
        cycle(0, 0, 1, 16'hFFFD, 0, 0, 0);
        check("load.sp", sp_o[0], 16'hFFFD);
        cycle(0, 0, 1, 16'h1234, 0, 0, 0);
        check("badload.sp", sp_o[0], 16'hFFFD);
        check("badload.err", 16'(le_o[0]), 16'd1);
        check("badload.fault", 16'(flt_o[0]), 16'd1);
        cycle(0, 0, 1, 16'hFFFE, 0, 0, 0);
        check("faultload.sp", sp_o[0], 16'hFFFE);
        cycle(0, 1, 0, 16'h0, 0, 0, 0);
        cycle(0, 0, 0, 16'h0, 1, 1, 0);
        check("pushpop.sp", sp_o[0], 16'hFFFE);
        check("pushpop.ovf", 16'(ov_o[0]), 16'd0);
        check("pushpop.unf", 16'(un_o[0]), 16'd0);
        cycle(0, 0, 1, 16'h0000, 0, 0, 0);
        check("pre_rst.fault", 16'(flt_o[0]), 16'd1);
        cycle(1, 0, 1, 16'hFFFC, 1, 0, 0);
        check("midrst.sp", sp_o[0], 16'hFFFF);
        check("midrst.err", 16'(le_o[0]), 16'd0);
        check("midrst.fault", 16'(flt_o[0]), 16'd0);

        // Random traffic; push-heavy so both bounds get exercised.
        for (int n = 0; n < 600; n++) begin
            int r;
            bit rs, cf, ld, pu, po, wc;
            logic [15:0] lv;
            r  = $urandom_range(0, 99);
            rs = (r < 2);
            cf = (r >= 2 && r < 8);
            ld = (r >= 8 && r < 16);
            pu = ($urandom_range(0, 99) < 45);
            po = ($urandom_range(0, 99) < 35);
            wc = ($urandom_range(0, 99) < 6);
            lv = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(16'hFFF5, 16'hFFFF));
            cycle(rs, cf, ld, lv, pu, po, wc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
